// File: rtl/ahb_req_arbiter.sv
// Round-robin front-end that shares one AHB-Lite master among NREQ requesters.
// One transaction is in flight at a time; data, ack and error go back to the winner.

module ahb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_dina,
    input  logic [NREQ*32-1:0]   req_dinb,
    input  logic [NREQ*2-1:0]    req_sel,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic                 m_enable,
    output logic                 m_wr,
    output logic [31:0]          m_addr,
    output logic [31:0]          m_dina,
    output logic [31:0]          m_dinb,
    output logic [1:0]           m_slave_sel,
    input  logic [31:0]          m_dout,
    input  logic                 m_hreadyout,
    input  logic                 m_hresp
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] win_q;
    logic [IDX_W-1:0] win_d;
    logic             win_found;
    logic [CNT_W-1:0] cnt_q;
    logic             err_r;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Winner is the first requester found searching last+1, last+2, ... wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        win_d     = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand     = (int'(last_q) + off) % NREQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_d     = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = ADDR;
            ADDR:    state_d = DATA;
            DATA:    if (m_hresp || m_hreadyout || cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        m_enable = (state_q == ADDR);
        ack      = (state_q == DONE) ? gnt : '0;
    end

    assign err = err_r;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= IDLE;
            last_q      <= IDX_LAST;
            win_q       <= '0;
            cnt_q       <= '0;
            err_r       <= 1'b0;
            rdata       <= '0;
            gnt         <= '0;
            m_wr        <= 1'b0;
            m_addr      <= '0;
            m_dina      <= '0;
            m_dinb      <= '0;
            m_slave_sel <= '0;
        end else begin
            // NOTE: non-blocking so every register here sees the pre-edge values of the others.
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        win_q       <= win_d;
                        gnt         <= NREQ'(1) << win_d;
                        m_wr        <= req_wr[win_d];
                        m_addr      <= req_addr[32*int'(win_d) +: 32];
                        m_dina      <= req_dina[32*int'(win_d) +: 32];
                        m_dinb      <= req_dinb[32*int'(win_d) +: 32];
                        m_slave_sel <= req_sel[2*int'(win_d) +: 2];
                    end
                end
                ADDR: cnt_q <= '0;
                DATA: begin
                    // Error beats ready; rdata is captured on writes too.
                    if (m_hresp) begin
                        err_r <= 1'b1;
                    end else if (m_hreadyout) begin
                        rdata <= m_dout;
                        err_r <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        err_r <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    last_q <= win_q;
                    gnt    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Randomised bench for ahb_req_arbiter: a timeline reference model predicts every
// grant, command and ack; a monitor compares the DUT against the queued predictions.

module tb_ahb_req_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic                hclk;
    logic                hreset;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_wr;
    logic [NREQ*32-1:0]  req_addr;
    logic [NREQ*32-1:0]  req_dina;
    logic [NREQ*32-1:0]  req_dinb;
    logic [NREQ*2-1:0]   req_sel;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     ack;
    logic                err;
    logic [31:0]         rdata;
    logic                busy;
    logic                m_enable;
    logic                m_wr;
    logic [31:0]         m_addr;
    logic [31:0]         m_dina;
    logic [31:0]         m_dinb;
    logic [1:0]          m_slave_sel;
    logic [31:0]         m_dout;
    logic                m_hreadyout;
    logic                m_hresp;

    ahb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .hclk(hclk), .hreset(hreset),
        .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_dina(req_dina), .req_dinb(req_dinb), .req_sel(req_sel),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .m_enable(m_enable), .m_wr(m_wr), .m_addr(m_addr),
        .m_dina(m_dina), .m_dinb(m_dinb), .m_slave_sel(m_slave_sel),
        .m_dout(m_dout), .m_hreadyout(m_hreadyout), .m_hresp(m_hresp)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
        int          ack_cyc;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] dina;
        logic [31:0] dinb;
        logic [1:0]  sel;
    } cmd_t;

    resp_t sb_q[$];
    cmd_t  cmd_q[$];
    int    obs_idx[$];
    int    obs_cyc[$];

    int tests = 0;
    int fails = 0;

    // Reference model state: a transaction picked at edge e_cyc spends d_len DATA cycles,
    // acks after edge e_cyc+1+d_len and frees the arbiter at edge e_cyc+2+d_len.
    int          cyc = 0;
    bit          mbusy = 0;
    int          e_cyc = 0;
    int          d_len = 0;
    int          w_idx = 0;
    int          rr_last = NREQ - 1;
    int          plan_kind = 0;  // 0 ok, 1 hresp, 2 timeout
    logic [31:0] plan_dout = '0;
    logic [31:0] last_rdata = '0;

    int          plan_mode = 0;  // 0 random, 1 fast ok, 2 timeout, 3 hresp on first DATA cycle
    bit          force_dout = 0;
    logic [31:0] force_val = '0;
    int          raise_pct = 0;
    int          keep_pct = 0;
    bit          jitter = 0;
    logic [NREQ-1:0] sticky = '0;
    bit          mon_en = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int obs_at(input int k);
        return (k < obs_idx.size()) ? obs_idx[k] : -1;
    endfunction

    function automatic int obs_cyc_at(input int k);
        return (k < obs_cyc.size()) ? obs_cyc[k] : -1;
    endfunction

    // Reference model, evaluated on the same edge the DUT samples.
    initial begin
        forever begin
            @(posedge hclk);
            cyc++;
            if (hreset) begin
                mbusy      = 0;
                rr_last    = NREQ - 1;
                last_rdata = '0;
                sb_q.delete();
                cmd_q.delete();
            end else if (mbusy) begin
                if (cyc == e_cyc + 2 + d_len) begin
                    mbusy   = 0;
                    rr_last = w_idx;
                end
            end else if (req != '0) begin
                w_idx = -1;
                for (int off = 1; off <= NREQ; off++) begin
                    int c;
                    c = (rr_last + off) % NREQ;
                    if (w_idx < 0 && req[c]) w_idx = c;
                end
                case (plan_mode)
                    1: begin plan_kind = 0; d_len = 1; end
                    2: begin plan_kind = 2; d_len = TIMEOUT; end
                    3: begin plan_kind = 1; d_len = 1; end
                    default: begin
                        int r;
                        r = int'($urandom_range(0, 9));
                        plan_kind = (r < 6) ? 0 : (r < 9) ? 1 : 2;
                        d_len = (plan_kind == 2) ? TIMEOUT : int'($urandom_range(1, 4));
                    end
                endcase
                plan_dout = force_dout ? force_val : $urandom;
                if (plan_kind == 0) last_rdata = plan_dout;
                sb_q.push_back('{idx: w_idx, err: (plan_kind != 0), rdata: last_rdata,
                                 ack_cyc: cyc + 1 + d_len});
                cmd_q.push_back('{cyc: cyc, wr: req_wr[w_idx], addr: req_addr[32*w_idx +: 32],
                                  dina: req_dina[32*w_idx +: 32], dinb: req_dinb[32*w_idx +: 32],
                                  sel: req_sel[2*w_idx +: 2]});
                e_cyc = cyc;
                mbusy = 1;
            end
        end
    end

    // Slave response, timed from the model; random noise outside DATA cycles.
    initial begin
        m_hreadyout = 1'b0;
        m_hresp     = 1'b0;
        m_dout      = '0;
        forever begin
            @(posedge hclk);
            #1;
            if (mbusy && cyc >= e_cyc + 1 && cyc <= e_cyc + d_len) begin
                if (cyc == e_cyc + d_len && plan_kind != 2) begin
                    m_hresp     = (plan_kind == 1);
                    m_hreadyout = (plan_kind == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                    m_dout      = (plan_kind == 0) ? plan_dout : $urandom;
                end else begin
                    m_hresp     = 1'b0;
                    m_hreadyout = 1'b0;
                    m_dout      = $urandom;
                end
            end else begin
                m_hresp     = 1'($urandom_range(0, 1));
                m_hreadyout = 1'($urandom_range(0, 1));
                m_dout      = $urandom;
            end
        end
    end

    // Monitor: per-cycle grant/busy/enable, plus queued ack and command comparisons.
    initial begin
        forever begin
            logic [NREQ-1:0] eg;
            resp_t r;
            cmd_t  c;
            @(negedge hclk);
            if (mon_en) begin
                eg = mbusy ? (NREQ'(1) << w_idx) : '0;
                check("gnt", gnt, eg);
                check("busy", busy, mbusy);
                check("m_enable", m_enable, mbusy && cyc == e_cyc);
                if (ack != '0) begin
                    for (int i = 0; i < NREQ; i++) if (ack[i]) obs_idx.push_back(i);
                    obs_cyc.push_back(cyc);
                end
                if (sb_q.size() > 0 && sb_q[0].ack_cyc == cyc) begin
                    r = sb_q.pop_front();
                    check("ack", ack, NREQ'(1) << r.idx);
                    check("err", err, r.err);
                    check("rdata", rdata, r.rdata);
                end else begin
                    check("no_ack", ack, '0);
                end
                if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
                    c = cmd_q.pop_front();
                    check("cmd_wr_addr_sel", {m_wr, m_slave_sel, m_addr}, {c.wr, c.sel, c.addr});
                    check("cmd_dina_dinb", {m_dina, m_dinb}, {c.dina, c.dinb});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    task automatic new_fields(input int i);
        req_wr[i]            = 1'($urandom_range(0, 1));
        req_addr[32*i +: 32] = $urandom;
        req_dina[32*i +: 32] = $urandom;
        req_dinb[32*i +: 32] = $urandom;
        req_sel[2*i +: 2]    = 2'($urandom_range(0, 3));
    endtask

    // One cycle of requester behaviour: drop or renew on ack, maybe raise, maybe jitter fields.
    task automatic step();
        logic [NREQ-1:0] a;
        @(negedge hclk);
        a = ack;
        @(posedge hclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (a[i] && req[i]) begin
                if (sticky[i] || $urandom_range(0, 99) < keep_pct) new_fields(i);
                else req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 99) < raise_pct) begin
                req[i] = 1'b1;
                new_fields(i);
            end else if (jitter && $urandom_range(0, 9) == 0) begin
                new_fields(i);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        req    = '0;
        sticky = '0;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        obs_idx.delete();
        obs_cyc.delete();
    endtask

    initial begin
        int t0;
        hreset = 1'b1;
        req = '0; req_wr = '0; req_addr = '0; req_dina = '0; req_dinb = '0; req_sel = '0;
        @(posedge hclk);
        #1;
        @(negedge hclk);
        check("rst_gnt", gnt, '0);
        check("rst_ack", ack, '0);
        check("rst_err_busy_en", {err, busy, m_enable, m_wr, m_slave_sel}, '0);
        check("rst_rdata", rdata, '0);
        check("rst_m_addr", m_addr, '0);
        check("rst_m_dina_dinb", {m_dina, m_dinb}, '0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        mon_en = 1;

        // Single write with an immediately ready slave.
        plan_mode = 1;
        req_wr[0] = 1'b1; req_addr[31:0] = 32'h10; req_dina[31:0] = 32'd5;
        req_dinb[31:0] = 32'd7; req_sel[1:0] = 2'd2;
        req[0] = 1'b1;
        t0 = cyc;
        steps(8);
        check("t1_ack_count", obs_idx.size(), 1);
        check("t1_ack_idx", obs_at(0), 0);
        check("t1_ack_latency", obs_cyc_at(0) - t0, 3);
        check("t1_m_addr_sel", {m_slave_sel, m_addr}, {2'd2, 32'h10});
        check("t1_err", err, 1'b0);

        // All four requesting at once: strict 0,1,2,3 at one ack per 4 cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) new_fields(i);
        req = '1;
        steps(20);
        for (int i = 0; i < NREQ; i++) check("t2_order", obs_at(i), i);
        for (int i = 1; i < NREQ; i++) check("t2_spacing", obs_cyc_at(i) - obs_cyc_at(i-1), 4);

        // Two permanent requesters alternate; a late requester 0 cuts in next.
        do_reset();
        sticky = 4'b0110;
        req = 4'b0110;
        steps(12);
        check("t3_first", obs_at(0), 1);
        check("t3_second", obs_at(1), 2);
        check("t3_third", obs_at(2), 1);
        new_fields(0);
        req[0] = 1'b1;
        steps(16);
        sticky = '0;
        steps(12);

        // Read returning a fixed pattern.
        do_reset();
        force_dout = 1; force_val = 32'hDEADBEEF;
        new_fields(2);
        req_wr[2] = 1'b0;
        req[2] = 1'b1;
        steps(8);
        force_dout = 0;
        check("t4_ack_idx", obs_at(0), 2);
        check("t4_rdata", rdata, 32'hDEADBEEF);
        check("t4_err", err, 1'b0);

        // Slave never ready: exactly TIMEOUT DATA cycles, then an error ack.
        do_reset();
        plan_mode = 2;
        new_fields(0);
        req[0] = 1'b1;
        t0 = cyc;
        steps(TIMEOUT + 8);
        check("t5_timeout_latency", obs_cyc_at(0) - t0, 2 + TIMEOUT);
        check("t5_timeout_err", err, 1'b1);

        // Error response on the first DATA cycle.
        plan_mode = 3;
        obs_idx.delete(); obs_cyc.delete();
        new_fields(1);
        req[1] = 1'b1;
        t0 = cyc;
        steps(6);
        check("t5_hresp_latency", obs_cyc_at(0) - t0, 3);
        check("t5_hresp_err", err, 1'b1);

        // Reset during DATA aborts the transaction; pending requester 0 goes first after.
        do_reset();
        plan_mode = 2;
        new_fields(1);
        req[1] = 1'b1;
        for (int n = 0; n < 10 && !(mbusy && cyc >= e_cyc + 2); n++) step();
        check("t6_in_data", mbusy && cyc >= e_cyc + 2, 1'b1);
        new_fields(0);
        req[0] = 1'b1;
        hreset = 1'b1;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("t6_rst_gnt_busy_ack", {gnt, busy, ack}, '0);
        plan_mode = 1;
        obs_idx.delete(); obs_cyc.delete();
        steps(12);
        check("t6_first_after_rst", obs_at(0), 0);
        check("t6_second_after_rst", obs_at(1), 1);

        // Random traffic with random slave behaviour and field jitter.
        do_reset();
        plan_mode = 0;
        raise_pct = 30;
        keep_pct  = 30;
        jitter    = 1;
        steps(1500);

        raise_pct = 0;
        keep_pct  = 0;
        for (int n = 0; n < 600 && (req != '0 || mbusy); n++) step();
        steps(2);
        check("drained", (req == '0) && !mbusy, 1'b1);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
